smi_read_requester: RTL and testbench

Client-side SMI read initiator feeding the request input of the SMI-to-AXI bus adaptor and consuming its response output. It converts simple (address, length) read commands into single-flit SMI read-request frames and strips the header from the returned response frames. The payload is presented to the client as a byte-counted data stream. It tracks the outstanding request count and checks response ordering by tag.

---
 rtl/smi_read_requester.sv | 181 ++++++++++++++++++
 tb/tb_smi_read_requester.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_read_requester.sv
// SMI read requester: turns (address, length) commands into single-flit SMI read requests and
// strips response headers into a byte-counted payload stream with tag-order checking.
module smi_read_requester #(
    parameter int unsigned FlitWidth = 16,
    parameter int unsigned TagWidth  = 4
) (
    input  logic                   clk,
    input  logic                   srst,

    input  logic                   cmdValid,
    output logic                   cmdReady,
    input  logic [63:0]            cmdAddr,
    input  logic [15:0]            cmdLen,
    output logic                   cmdError,

    output logic                   smiReqReady,
    output logic [7:0]             smiReqEofc,
    output logic [FlitWidth*8-1:0] smiReqData,
    input  logic                   smiReqStop,

    input  logic                   smiRespReady,
    input  logic [7:0]             smiRespEofc,
    input  logic [FlitWidth*8-1:0] smiRespData,
    output logic                   smiRespStop,

    output logic                   dataValid,
    input  logic                   dataReady,
    output logic [FlitWidth*8-1:0] data,
    output logic [7:0]             dataBytes,
    output logic                   dataLast,
    output logic                   dataErr,
    output logic                   tagError
);

    localparam int unsigned FlitBits = FlitWidth * 8;
    localparam logic [7:0] FullEofc = 8'(FlitWidth);
    localparam logic [TagWidth:0] OutstandingMax = {1'b1, {TagWidth{1'b0}}};

    localparam logic [0:0] ReqIdle  = 1'b0;
    localparam logic [0:0] ReqSend  = 1'b1;
    localparam logic [0:0] RespHdr  = 1'b0;
    localparam logic [0:0] RespData = 1'b1;

    logic [0:0]          reqStateQ, reqStateD;
    logic [FlitBits-1:0] reqFlitQ, reqFlitD;
    logic [TagWidth-1:0] reqTagQ;
    logic [TagWidth-1:0] expTagQ;
    logic [TagWidth:0]   outstandingQ;
    logic                cmdErrorQ;
    logic                tagErrorQ;
    logic [0:0]          respStateQ, respStateD;

    logic cmdAccept;
    logic reqXfer;
    logic eofcNz;
    logic hdrAccept;
    logic respDone;
    logic outDec;
    logic tagMismatch;

    // ---------------------------------------------------------------- request side

    assign cmdReady  = (reqStateQ == ReqIdle) && (outstandingQ < OutstandingMax);
    assign cmdAccept = cmdValid && cmdReady;
    assign reqXfer   = (reqStateQ == ReqSend) && !smiReqStop;

    always_comb begin
        reqStateD = reqStateQ;
        reqFlitD  = reqFlitQ;
        case (reqStateQ)
            ReqIdle: begin
                if (cmdAccept && (cmdLen != 16'd0)) begin
                    reqFlitD          = '0;
                    reqFlitD[7:0]     = 8'h02;
                    reqFlitD[15:8]    = 8'(reqTagQ);
                    reqFlitD[31:16]   = cmdLen;
                    reqFlitD[127:64]  = cmdAddr;
                    reqStateD         = ReqSend;
                end
            end
            ReqSend: begin
                if (!smiReqStop) begin
                    reqFlitD  = '0;
                    reqStateD = ReqIdle;
                end
            end
            default: reqStateD = ReqIdle;
        endcase
    end

    assign smiReqReady = (reqStateQ == ReqSend);
    assign smiReqEofc  = smiReqReady ? FullEofc : 8'd0;
    assign smiReqData  = reqFlitQ;
    assign cmdError    = cmdErrorQ;

    // ---------------------------------------------------------------- response side

    assign eofcNz = (smiRespEofc != 8'd0);

    always_comb begin
        respStateD  = respStateQ;
        dataValid   = 1'b0;
        data        = '0;
        dataBytes   = 8'd0;
        dataLast    = 1'b0;
        dataErr     = 1'b0;
        smiRespStop = 1'b0;
        hdrAccept   = 1'b0;
        respDone    = 1'b0;
        case (respStateQ)
            RespHdr: begin
                if (eofcNz) begin
                    // Header-only error frame is surfaced as a single zero-byte error beat.
                    dataValid   = smiRespReady;
                    dataLast    = 1'b1;
                    dataErr     = 1'b1;
                    smiRespStop = !dataReady;
                    hdrAccept   = smiRespReady && dataReady;
                    respDone    = hdrAccept;
                end else begin
                    hdrAccept = smiRespReady;
                    if (hdrAccept) begin
                        respStateD = RespData;
                    end
                end
            end
            RespData: begin
                dataValid   = smiRespReady;
                data        = smiRespData;
                smiRespStop = !dataReady;
                dataLast    = eofcNz;
                dataBytes   = eofcNz ? smiRespEofc : FullEofc;
                if (smiRespReady && dataReady && eofcNz) begin
                    respDone   = 1'b1;
                    respStateD = RespHdr;
                end
            end
            default: respStateD = RespHdr;
        endcase
    end

    assign tagMismatch = hdrAccept && (smiRespData[15:8] != 8'(expTagQ));
    assign outDec      = respDone && (outstandingQ != '0);
    assign tagError    = tagErrorQ;

    // ---------------------------------------------------------------- state

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            reqStateQ    <= ReqIdle;
            reqFlitQ     <= '0;
            reqTagQ      <= '0;
            expTagQ      <= '0;
            outstandingQ <= '0;
            cmdErrorQ    <= 1'b0;
            tagErrorQ    <= 1'b0;
            respStateQ   <= RespHdr;
        end else begin
            reqStateQ  <= reqStateD;
            reqFlitQ   <= reqFlitD;
            respStateQ <= respStateD;
            cmdErrorQ  <= cmdAccept && (cmdLen == 16'd0);
            tagErrorQ  <= tagErrorQ | tagMismatch;
            if (reqXfer) begin
                reqTagQ <= reqTagQ + TagWidth'(1);
            end
            if (respDone) begin
                expTagQ <= expTagQ + TagWidth'(1);
            end
            case ({reqXfer, outDec})
                2'b10:   outstandingQ <= outstandingQ + (TagWidth + 1)'(1);
                2'b01:   outstandingQ <= outstandingQ - (TagWidth + 1)'(1);
                default: outstandingQ <= outstandingQ;
            endcase
        end
    end

    // Outstanding count must never exceed the tag space.
    assert property (@(posedge clk) disable iff (srst) outstandingQ <= OutstandingMax);

endmodule

// File: tb/tb_smi_read_requester.sv
// Scoreboard bench for smi_read_requester: drivers push expected request flits and payload
// beats into queues; negedge monitors pop and compare whenever the DUT transfers.
module tb_smi_read_requester;

    typedef struct {
        logic [127:0] d;
        logic [7:0]   n;
        logic         last;
        logic         err;
    } beat_t;

    logic         clk = 1'b0;
    logic         srst = 1'b1;
    logic         cmdValid = 1'b0;
    logic         cmdReady;
    logic [63:0]  cmdAddr = '0;
    logic [15:0]  cmdLen = '0;
    logic         cmdError;
    logic         smiReqReady;
    logic [7:0]   smiReqEofc;
    logic [127:0] smiReqData;
    logic         smiReqStop = 1'b0;
    logic         smiRespReady = 1'b0;
    logic [7:0]   smiRespEofc = '0;
    logic [127:0] smiRespData = '0;
    logic         smiRespStop;
    logic         dataValid;
    logic         dataReady = 1'b1;
    logic [127:0] data;
    logic [7:0]   dataBytes;
    logic         dataLast;
    logic         dataErr;
    logic         tagError;

    int total = 0;
    int bad = 0;
    int tbReqTag = 0;
    bit toggleRdy = 1'b0;
    logic [127:0] reqQ[$];
    beat_t beatQ[$];

    smi_read_requester #(.FlitWidth(16), .TagWidth(4)) dut (
        .clk(clk), .srst(srst),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdAddr(cmdAddr), .cmdLen(cmdLen),
        .cmdError(cmdError),
        .smiReqReady(smiReqReady), .smiReqEofc(smiReqEofc), .smiReqData(smiReqData),
        .smiReqStop(smiReqStop),
        .smiRespReady(smiRespReady), .smiRespEofc(smiRespEofc), .smiRespData(smiRespData),
        .smiRespStop(smiRespStop),
        .dataValid(dataValid), .dataReady(dataReady), .data(data), .dataBytes(dataBytes),
        .dataLast(dataLast), .dataErr(dataErr), .tagError(tagError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] flitOf(input int tag, input logic [15:0] len,
                                            input logic [63:0] addr);
        logic [127:0] f;
        f = '0;
        f[7:0] = 8'h02;
        f[15:8] = 8'(tag);
        f[31:16] = len;
        f[127:64] = addr;
        return f;
    endfunction

    // Request monitor
    initial forever begin
        @(negedge clk);
        if (smiReqReady && !smiReqStop) begin
            if (reqQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL reqUnexpected: got flit %0h, expected none", smiReqData);
            end else begin
                logic [127:0] e;
                e = reqQ.pop_front();
                chk("reqFlit", smiReqData, e);
                chk("reqEofc", 128'(smiReqEofc), 128'(16));
            end
        end
    end

    // Payload monitor
    initial forever begin
        @(negedge clk);
        if (dataValid && dataReady) begin
            if (beatQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL beatUnexpected: got beat %0h, expected none", data);
            end else begin
                beat_t b;
                b = beatQ.pop_front();
                chk("beatData", data, b.d);
                chk("beatBytes", 128'(dataBytes), 128'(b.n));
                chk("beatLast", 128'(dataLast), 128'(b.last));
                chk("beatErr", 128'(dataErr), 128'(b.err));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (toggleRdy) dataReady = ~dataReady;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at acceptance edge+1.
    task automatic sendCmd(input logic [63:0] addr, input logic [15:0] len);
        int n;
        n = 0;
        cmdValid = 1'b1;
        cmdAddr = addr;
        cmdLen = len;
        while (!cmdReady && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmdReady) begin
            total++;
            bad++;
            $display("FAIL cmdTimeout: got cmdReady=0 expected 1 within 50 cycles");
            cmdValid = 1'b0;
            return;
        end
        if (len != 16'd0) begin
            reqQ.push_back(flitOf(tbReqTag, len, addr));
            tbReqTag = (tbReqTag + 1) % 16;
        end
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
    endtask

    task automatic driveFlit(input logic [127:0] f, input logic [7:0] e, input bit chkStop);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        smiRespReady = 1'b1;
        smiRespData = f;
        smiRespEofc = e;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (chkStop) chk("respStop", 128'(smiRespStop), 128'(!dataReady));
            acc = !smiRespStop;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL respTimeout: got smiRespStop=1 expected accept within 50 cycles");
        end
    endtask

    task automatic respFrame(input int tag, input int status, input int nbytes,
                             input logic [7:0] seed, input bit chkStop);
        logic [127:0] f;
        logic [7:0] e;
        logic [7:0] pat;
        int nflits;
        f = '0;
        f[15:8] = 8'(tag);
        f[23:16] = 8'(status);
        if (status != 0) begin
            beatQ.push_back('{128'd0, 8'd0, 1'b1, 1'b1});
            driveFlit(f, 8'd16, 1'b0);
        end else begin
            driveFlit(f, 8'd0, 1'b0);
            nflits = (nbytes + 15) / 16;
            for (int k = 0; k < nflits; k++) begin
                pat = seed + 8'(k);
                f = {16{pat}};
                e = (k == nflits - 1) ? 8'(nbytes - 16 * k) : 8'd0;
                beatQ.push_back('{f, (e != 0) ? e : 8'd16, e != 0, 1'b0});
                driveFlit(f, e, chkStop);
            end
        end
        smiRespReady = 1'b0;
        smiRespEofc = '0;
        smiRespData = '0;
    endtask

    task automatic doReset();
        srst = 1'b1;
        @(posedge clk);
        #1;
        reqQ.delete();
        beatQ.delete();
        tbReqTag = 0;
        srst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rstCmdReady", 128'(cmdReady), 128'(1));
        chk("rstReqReady", 128'(smiReqReady), 128'(0));
        chk("rstReqEofc", 128'(smiReqEofc), 128'(0));
        chk("rstReqData", smiReqData, 128'(0));
        chk("rstCmdError", 128'(cmdError), 128'(0));
        chk("rstTagError", 128'(tagError), 128'(0));
        chk("rstRespStop", 128'(smiRespStop), 128'(0));
        chk("rstDataValid", 128'(dataValid), 128'(0));
        @(posedge clk);
        #1;
        srst = 1'b0;
        @(posedge clk);
        #1;

        // Single read 0x1000 / 40 bytes
        sendCmd(64'h1000, 16'd40);
        chk("firstReqReady", 128'(smiReqReady), 128'(1));
        chk("firstFlit", smiReqData, 128'h0000000000001000_0000000000280002);
        chk("firstEofc", 128'(smiReqEofc), 128'(16));
        chk("sendCmdReady", 128'(cmdReady), 128'(0));
        @(posedge clk);
        #1;
        chk("afterXferCmdReady", 128'(cmdReady), 128'(1));
        chk("afterXferReqReady", 128'(smiReqReady), 128'(0));
        respFrame(0, 0, 40, 8'h10, 1'b0);
        chk("single3Beats", 128'(beatQ.size()), 128'(0));

        // Request backpressure
        smiReqStop = 1'b1;
        sendCmd(64'h2000, 16'd64);
        for (int i = 0; i < 5; i++) begin
            chk("stallFlit", smiReqData, 128'h0000000000002000_0000000000400102);
            chk("stallEofc", 128'(smiReqEofc), 128'(16));
            chk("stallCmdReady", 128'(cmdReady), 128'(0));
            @(posedge clk);
            #1;
        end
        smiReqStop = 1'b0;
        @(posedge clk);
        #1;
        chk("stallDone", 128'(smiReqReady), 128'(0));
        chk("stallReqQ", 128'(reqQ.size()), 128'(0));
        // Payload backpressure with toggling dataReady
        toggleRdy = 1'b1;
        respFrame(1, 0, 64, 8'h40, 1'b1);
        toggleRdy = 1'b0;
        dataReady = 1'b1;
        chk("toggleBeatQ", 128'(beatQ.size()), 128'(0));
        doReset();

        // Fill all 16 tags
        for (int i = 0; i < 16; i++) sendCmd(64'h100 * i, 16'd16);
        @(posedge clk);
        #1;
        chk("fullCmdReady", 128'(cmdReady), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("fullCmdReadyHeld", 128'(cmdReady), 128'(0));
        chk("fillReqQ", 128'(reqQ.size()), 128'(0));
        respFrame(0, 0, 16, 8'h77, 1'b0);
        chk("freeCmdReady", 128'(cmdReady), 128'(1));

        // 17th request transfers in the same cycle an error frame completes
        chk("simCmdReady", 128'(cmdReady), 128'(1));
        cmdValid = 1'b1;
        cmdAddr = 64'hABCD;
        cmdLen = 16'd8;
        reqQ.push_back(flitOf(tbReqTag, 16'd8, 64'hABCD));
        tbReqTag = (tbReqTag + 1) % 16;
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        chk("wrapTag", 128'(smiReqData[15:8]), 128'(0));
        smiRespReady = 1'b1;
        smiRespData = 128'h0000_0000_0000_0000_0000_0000_0003_0100;
        smiRespEofc = 8'd16;
        beatQ.push_back('{128'd0, 8'd0, 1'b1, 1'b1});
        @(posedge clk);
        #1;
        smiRespReady = 1'b0;
        smiRespEofc = '0;
        chk("simOutstanding", 128'(cmdReady), 128'(1));
        sendCmd(64'h3000, 16'd8);
        @(posedge clk);
        #1;
        chk("simFullAgain", 128'(cmdReady), 128'(0));
        respFrame(2, 0, 8, 8'h55, 1'b0);

        // Zero-length command
        sendCmd(64'h5000, 16'd0);
        chk("zeroCmdError", 128'(cmdError), 128'(1));
        chk("zeroNoFrame", 128'(smiReqReady), 128'(0));
        @(posedge clk);
        #1;
        chk("zeroCmdErrorPulse", 128'(cmdError), 128'(0));
        chk("zeroNoFrame2", 128'(smiReqReady), 128'(0));

        // Tag mismatch: expected 3, got 5
        chk("tagErrBefore", 128'(tagError), 128'(0));
        respFrame(5, 3, 0, 8'h00, 1'b0);
        chk("tagErrSet", 128'(tagError), 128'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("tagErrHeld", 128'(tagError), 128'(1));
        chk("midQueuesReq", 128'(reqQ.size()), 128'(0));
        chk("midQueuesBeat", 128'(beatQ.size()), 128'(0));

        // Asynchronous reset mid response frame with a held request flit
        smiReqStop = 1'b1;
        sendCmd(64'h6000, 16'd16);
        dataReady = 1'b0;
        smiRespReady = 1'b1;
        smiRespData = 128'h0300;
        smiRespEofc = 8'd0;
        @(posedge clk);
        #1;
        smiRespData = {16{8'hAA}};
        chk("midValid", 128'(dataValid), 128'(1));
        chk("midStop", 128'(smiRespStop), 128'(1));
        #2;
        srst = 1'b1;
        #1;
        chk("arstDataValid", 128'(dataValid), 128'(0));
        chk("arstRespStop", 128'(smiRespStop), 128'(0));
        chk("arstReqReady", 128'(smiReqReady), 128'(0));
        chk("arstReqData", smiReqData, 128'(0));
        chk("arstReqEofc", 128'(smiReqEofc), 128'(0));
        chk("arstTagError", 128'(tagError), 128'(0));
        chk("arstCmdReady", 128'(cmdReady), 128'(1));
        smiRespReady = 1'b0;
        smiRespData = '0;
        smiReqStop = 1'b0;
        dataReady = 1'b1;
        reqQ.delete();
        beatQ.delete();
        tbReqTag = 0;
        @(posedge clk);
        #1;
        srst = 1'b0;
        @(posedge clk);
        #1;
        sendCmd(64'h7000, 16'd20);
        chk("postRstFlit", smiReqData, 128'h0000000000007000_0000000000140002);
        @(posedge clk);
        #1;
        respFrame(0, 0, 20, 8'h30, 1'b0);
        chk("postRstTagError", 128'(tagError), 128'(0));
        chk("endReqQ", 128'(reqQ.size()), 128'(0));
        chk("endBeatQ", 128'(beatQ.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
